// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and constant helpers for the button debouncer
//
// Purpose: width calculation for the per-channel counters, the idle pin level
// for a given polarity, and the auto-repeat state encoding.
package debounce_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_PERIOD = 2'd2
  } rpt_state_t;

  // Number of bits needed to hold the values 0 .. v-1 (minimum 1).
  function automatic int clog2_w(input longint unsigned v);
    int w;
    longint unsigned x;
    w = 0;
    x = (v == 0) ? 0 : v - 1;
    while (x != 0) begin
      w = w + 1;
      x = x >> 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Pin value seen when nothing is pressed.
  function automatic logic inactive_level(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/multi_button_debouncer_if.sv
// rtl/multi_button_debouncer_if.sv - pin-side and event-side bundle of the debouncer
//
// Purpose: groups the raw pins and the cleaned-up per-channel outputs.
// Ports (signals):
//   raw_in         raw asynchronous pin levels
//   level          debounced, normalised state (1 = pressed)
//   press          one-cycle pulse on debounced 0->1
//   release_pulse  one-cycle pulse on debounced 1->0
//   press_rpt      press or auto-repeat pulse
// Modports: slave = the debouncer, master = the pin driver / event consumer.
interface multi_button_debouncer_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0] raw_in;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] press;
  logic [NUM_CH-1:0] release_pulse;
  logic [NUM_CH-1:0] press_rpt;

  modport master (
    output raw_in,
    input  level,
    input  press,
    input  release_pulse,
    input  press_rpt
  );

  modport slave (
    input  raw_in,
    output level,
    output press,
    output release_pulse,
    output press_rpt
  );
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one debounced button: synchroniser, stability counter, edges, repeat
//
// Purpose: cleans a single raw pin into a level plus press/release/repeat pulses.
// Ports:
//   clk            system clock
//   resetn         asynchronous, active-low reset
//   raw_in         raw asynchronous pin
//   level          debounced, normalised state
//   press          one-cycle pulse on debounced 0->1
//   release_pulse  one-cycle pulse on debounced 1->0
//   press_rpt      press or auto-repeat pulse
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter bit REPEAT_ENABLE   = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic press_rpt
);

  localparam int CNT_W =
    clog2_w(longint'(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1);
  localparam logic             INACTIVE = inactive_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic             sync_s1;
  logic             sync_s2;
  logic             norm;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] stab_cnt_d;
  logic             level_d;
  logic             press_d;
  logic             rel_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0] hold_inc;
  logic [CNT_W-1:0] hold_target;
  logic             rpt_fire;
  rpt_state_t       rpt_state;
  rpt_state_t       rpt_state_d;

  assign norm = ACTIVE_LOW ? ~sync_s2 : sync_s2;

  // Stability counter: the level flips only after the synchronised sample has
  // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    level_d    = level;
    stab_cnt_d = '0;
    if (norm != level) begin
      if (stab_cnt == DEB_LAST) begin
        level_d = norm;
      end else begin
        stab_cnt_d = stab_cnt + 1'b1;
      end
    end
    press_d = level_d & ~level;
    rel_d   = ~level_d & level;
  end

  // Auto-repeat: counts cycles held since the press; the first target is
  // REPEAT_DELAY, then REPEAT_PERIOD. Everything is decided on the level the
  // register is about to take, so a release on a due cycle cancels the repeat
  // and the press cycle itself never fires one.
  always_comb begin
    rpt_state_d = rpt_state;
    hold_cnt_d  = hold_cnt;
    rpt_fire    = 1'b0;
    hold_inc    = hold_cnt + 1'b1;
    hold_target = (rpt_state == RPT_DELAY) ? DELAY_C : PERIOD_C;
    case (rpt_state)
      RPT_IDLE: begin
        hold_cnt_d = '0;
        if (REPEAT_ENABLE && press_d) begin
          rpt_state_d = RPT_DELAY;
        end
      end
      RPT_DELAY, RPT_PERIOD: begin
        if (!level_d) begin
          rpt_state_d = RPT_IDLE;
          hold_cnt_d  = '0;
        end else if (hold_inc == hold_target) begin
          rpt_fire    = 1'b1;
          hold_cnt_d  = '0;
          rpt_state_d = RPT_PERIOD;
        end else begin
          hold_cnt_d = hold_inc;
        end
      end
      default: begin
        rpt_state_d = RPT_IDLE;
        hold_cnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_s1       <= INACTIVE;
      sync_s2       <= INACTIVE;
      level         <= 1'b0;
      stab_cnt      <= '0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      press_rpt     <= 1'b0;
      hold_cnt      <= '0;
      rpt_state     <= RPT_IDLE;
    end else begin
      sync_s1       <= raw_in;
      sync_s2       <= sync_s1;
      level         <= level_d;
      stab_cnt      <= stab_cnt_d;
      press         <= press_d;
      release_pulse <= rel_d;
      press_rpt     <= press_d | rpt_fire;
      hold_cnt      <= hold_cnt_d;
      rpt_state     <= rpt_state_d;
    end
  end

endmodule

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - N independent button debouncers behind one bundle
//
// Purpose: replicates debounce_channel per pin; channels share nothing but clock/reset.
// Ports:
//   clk     system clock
//   resetn  asynchronous, active-low reset
//   bus     slave side of multi_button_debouncer_if (raw_in in; level, press,
//           release_pulse, press_rpt out)
module multi_button_debouncer
  import debounce_pkg::*;
#(
  parameter int              NUM_CH          = 4,
  parameter int              DEBOUNCE_CYCLES = 1000000,
  parameter bit              ACTIVE_LOW      = 1'b1,
  parameter logic [NUM_CH-1:0] REPEAT_EN     = '0,
  parameter int              REPEAT_DELAY    = 25000000,
  parameter int              REPEAT_PERIOD   = 5000000
) (
  input  logic                     clk,
  input  logic                     resetn,
  multi_button_debouncer_if.slave  bus
);

  logic [NUM_CH-1:0] level_w;
  logic [NUM_CH-1:0] press_w;
  logic [NUM_CH-1:0] rel_w;
  logic [NUM_CH-1:0] rpt_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_ENABLE   (REPEAT_EN[i]),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk           (clk),
      .resetn        (resetn),
      .raw_in        (bus.raw_in[i]),
      .level         (level_w[i]),
      .press         (press_w[i]),
      .release_pulse (rel_w[i]),
      .press_rpt     (rpt_w[i])
    );
  end

  assign bus.level         = level_w;
  assign bus.press         = press_w;
  assign bus.release_pulse = rel_w;
  assign bus.press_rpt     = rpt_w;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb/tb_multi_button_debouncer.sv - randomized self-checking bench for multi_button_debouncer
module tb_multi_button_debouncer;

  localparam int         NUM_CH = 4;
  localparam int         DEB    = 4;
  localparam bit         ACT_LO = 1'b1;
  localparam logic [3:0] REP_EN = 4'b0001;
  localparam int         RDEL   = 10;
  localparam int         RPER   = 3;
  localparam int         MAXE   = 4096;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  multi_button_debouncer_if #(.NUM_CH(NUM_CH)) dut_if ();

  multi_button_debouncer #(
    .NUM_CH          (NUM_CH),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (ACT_LO),
    .REPEAT_EN       (REP_EN),
    .REPEAT_DELAY    (RDEL),
    .REPEAT_PERIOD   (RPER)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dut_if)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         e        = 0;    // clock edges since start (not advanced while in reset)
  int         epoch    = 0;    // edge count at the last reset release
  logic [3:0] raw_hist [0:MAXE];
  logic [3:0] lvl_m    [0:MAXE];
  int         press_at [NUM_CH];
  logic [3:0] rep_en_v;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got=%b exp=%b", tag, e, got, exp);
  endtask

  // "Pressed" as seen from the raw pin sampled at edge x; before the reset
  // release the synchroniser holds the idle pin value.
  function automatic logic pressed_at(input int x, input int c);
    logic r;
    if (x <= epoch) r = ACT_LO ? 1'b1 : 1'b0;
    else            r = raw_hist[x][c];
    return ACT_LO ? ~r : r;
  endfunction

  task automatic step(input logic [3:0] v);
    logic [3:0] lv, pr, rl, rp, prev;
    bit         flip;
    int         d;
    dut_if.raw_in = v;
    @(posedge clk);
    #1;
    e++;
    if (e >= MAXE) begin
      $display("FAIL edge_budget edge=%0d limit=%0d", e, MAXE);
      $fatal(1);
    end
    raw_hist[e] = v;
    prev = lvl_m[e-1];
    // A level change needs DEB consecutive post-reset cycles whose
    // synchronised (two-edge-old) sample disagreed with the current level.
    for (int c = 0; c < NUM_CH; c++) begin
      flip = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if ((e - j) <= epoch || pressed_at(e - j - 2, c) == prev[c]) flip = 1'b0;
      end
      lv[c] = flip ? ~prev[c] : prev[c];
    end
    pr = lv & ~prev;
    rl = ~lv & prev;
    rp = pr;
    for (int c = 0; c < NUM_CH; c++) begin
      if (pr[c]) begin
        press_at[c] = e;
      end else if (rep_en_v[c] && lv[c] && prev[c]) begin
        d = e - press_at[c];
        if (d >= RDEL && ((d - RDEL) % RPER) == 0) rp[c] = 1'b1;
      end
    end
    lvl_m[e] = lv;
    check("level",     dut_if.level,         lv);
    check("press",     dut_if.press,         pr);
    check("release",   dut_if.release_pulse, rl);
    check("press_rpt", dut_if.press_rpt,     rp);
  endtask

  task automatic step_n(input logic [3:0] v, input int n);
    for (int k = 0; k < n; k++) step(v);
  endtask

  task automatic do_reset(input int n_edges);
    resetn = 1'b0;
    #1;
    check("rst_level",     dut_if.level,         4'b0000);
    check("rst_press",     dut_if.press,         4'b0000);
    check("rst_release",   dut_if.release_pulse, 4'b0000);
    check("rst_press_rpt", dut_if.press_rpt,     4'b0000);
    for (int k = 0; k < n_edges; k++) begin
      @(posedge clk);
      #1;
      check("rst_hold_level", dut_if.level, 4'b0000);
      check("rst_hold_press", dut_if.press | dut_if.press_rpt | dut_if.release_pulse, 4'b0000);
    end
    resetn = 1'b1;
    epoch = e;
    lvl_m[e] = 4'b0000;
    for (int c = 0; c < NUM_CH; c++) press_at[c] = -1000;
  endtask

  initial begin
    logic [3:0] v;
    rep_en_v = REP_EN;
    resetn = 1'b1;
    dut_if.raw_in = 4'b1111;
    lvl_m[0] = 4'b0000;
    #2;
    do_reset(3);

    // ch0 and ch2 held 36 cycles: only ch0 repeats
    step_n(4'b1111, 5);
    step_n(4'b1010, 36);
    step_n(4'b1111, 12);
    // ch0 pressed again: repeat timing restarts
    step_n(4'b1110, 20);
    step_n(4'b1111, 10);
    // ch1 bounce: low 3, high 1, then steady low
    step_n(4'b1101, 3);
    step_n(4'b1111, 1);
    step_n(4'b1101, 12);
    step_n(4'b1111, 10);
    // all channels together
    step_n(4'b0000, 10);
    step_n(4'b1111, 10);
    // reset while ch0 is high and ch1 is mid-count, pins kept pressed
    step_n(4'b1110, 8);
    step_n(4'b1100, 3);
    do_reset(3);
    step_n(4'b1100, 12);
    step_n(4'b1111, 10);

    // random pin activity: bouncy phase, then long-hold phase
    v = 4'b1111;
    for (int k = 0; k < 700; k++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 7) == 0) v[c] = ~v[c];
      step(v);
    end
    for (int k = 0; k < 700; k++) begin
      for (int c = 0; c < NUM_CH; c++) if ($urandom_range(0, 23) == 0) v[c] = ~v[c];
      step(v);
    end
    step_n(4'b1111, 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_button_debouncer.md
Name: multi_button_debouncer

Overview:
Parametrised N-channel debouncer for the board's push-buttons and switches. Each channel has a 2-flop synchroniser, polarity normalisation and a per-channel stability counter. Outputs are a clean level plus one-cycle press and release pulses, with optional hold-to-repeat pulses for column-select buttons. It sits between the raw KEY/SW pins and the game-control FSM and replaces the single-channel debouncer.

Parameters:
NUM_CH, 4, number of independent channels
DEBOUNCE_CYCLES, 1000000, consecutive stable post-sync cycles required before a level change (>=1)
CNT_W, clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)+1), counter width; derived, do not override
ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed (DE-board KEYs); 0 = active-high
REPEAT_EN, {NUM_CH{1'b0}}, per-channel bitmask enabling auto-repeat
REPEAT_DELAY, 25000000, cycles from press until the first repeat pulse (>=1)
REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (>=1)

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous, active-low reset
raw_in  in  NUM_CH  raw asynchronous pin inputs
level  out  NUM_CH  debounced, normalised state (1 = pressed/asserted)
press  out  NUM_CH  one-cycle pulse on debounced 0->1
release  out  NUM_CH  one-cycle pulse on debounced 1->0
press_rpt  out  NUM_CH  press OR auto-repeat pulse (one cycle each)

Behaviour:
- Reset (async assert, sync-released use by downstream): synchroniser flops load the inactive pin value (ACTIVE_LOW ? 1 : 0). level, press, release, press_rpt = 0. All counters = 0. Assertion mid-operation aborts any count immediately; no pulse is emitted on reset entry or exit.
- Synchroniser: raw_in -> s1 -> s2, per bit. Normalised sample n = ACTIVE_LOW ? ~s2 : s2.
- Stability counter, per channel:
  - n == level: counter <= 0 (any bounce back restarts the count).
  - n != level and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - n != level and counter == DEBOUNCE_CYCLES-1: level <= n, counter <= 0.
  - The counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.
- Latency: a clean raw edge appears on level exactly 2 + DEBOUNCE_CYCLES clocks later. With DEBOUNCE_CYCLES = 1, level follows n with a 1-cycle delay.
- press/release: registered outputs, high for exactly the first cycle in which level holds its new value. They are never asserted in the same cycle on the same channel.
- Auto-repeat (REPEAT_EN[i] = 1 only):
  - A hold counter clears on any cycle where level = 0 and in the press cycle.
  - While level = 1 it increments. On reaching REPEAT_DELAY it fires a repeat pulse; thereafter a pulse fires every REPEAT_PERIOD cycles until release.
  - Repeat pulses never coincide with press.
  - A release in the same cycle a repeat is due suppresses that repeat.
- press_rpt = press | repeat pulse. When REPEAT_EN[i] = 0, press_rpt[i] == press[i].
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Package debounce_pkg: clog2-style width function, and the ACTIVE_LOW inactive-level constant helper.
- Sub-module debounce_channel: one synchroniser, stability counter, edge and repeat logic, with the same parameters minus NUM_CH plus a scalar REPEAT_ENABLE. The top level instantiates it NUM_CH times via generate.

Test Plan:
(Params: NUM_CH=4, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, REPEAT_EN=4'b0001, REPEAT_DELAY=10, REPEAT_PERIOD=3)
1. raw_in[0] 1->0 cleanly at cycle t -> level[0] rises at t+6; press[0] and press_rpt[0] high only at t+6; release[0] stays 0.
2. raw_in[1] toggles low for 3 cycles, then high 1 cycle, then low steadily -> no glitch on level[1]; it rises 4 stable cycles (+2 sync) after the final low edge.
3. Hold raw_in[0] low 30 cycles after press at cycle P -> press_rpt[0] pulses at P, P+10, P+13, P+16, ...; press[0] only at P. Channel 2 held low the same way -> press_rpt[2] pulses only at press.
4. Release raw_in[0] at cycle R -> release[0] one cycle at R+6; level[0] = 0; no further press_rpt[0] pulses; repeat timing restarts fresh on the next press.
5. All four channels pressed on the same cycle -> press = 4'b1111 in a single cycle; level = 4'b1111.
6. Assert resetn = 0 mid-count and while level[0] = 1 -> outputs all 0 immediately; after release of reset with pins still pressed, level rises 6 cycles later with a fresh press pulse.
